// File: rtl/point_tracker_pkg.sv
// rtl/point_tracker_pkg.sv - shared constants, FSM state type and marker test for point_tracker
package point_tracker_pkg;

  localparam int unsigned FRAME_W_DEF = 640;
  localparam int unsigned FRAME_H_DEF = 480;

  localparam int unsigned SUM_H_W    = 29;
  localparam int unsigned SUM_V_W    = 28;
  localparam int unsigned CNT_W      = 19;
  localparam int unsigned DIV_CYCLES = 29;

  typedef enum logic [1:0] {
    IDLE,
    DIV_H,
    DIV_V,
    EMIT
  } tracker_state_t;

  // Colour layout is {R, G, B}, 10 bits each.
  function automatic logic is_marker(input logic        valid,
                                     input logic [29:0] color,
                                     input logic [9:0]  g_th,
                                     input logic [9:0]  rb_th);
    return valid && (color[19:10] >= g_th) && (color[29:20] < rb_th) && (color[9:0] < rb_th);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring shift-subtract divider, one quotient bit per cycle
// The first bit is resolved on the start edge so o_done lands on the 29th cycle after start.
module serial_divider
  import point_tracker_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [SUM_H_W-1:0] i_dividend,
  input  logic [CNT_W-1:0]   i_divisor,
  output logic [SUM_H_W-1:0] o_quot,
  output logic               o_done
);

  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [SUM_H_W-1:0] quot_q, quot_d;
  logic [4:0]         step_q, step_d;
  logic               busy_q, busy_d;

  logic [CNT_W-1:0]   rem_in, div_in;
  logic [SUM_H_W-1:0] quot_in;
  logic [CNT_W:0]     trial;
  logic               fits;

  assign o_done = busy_q && (step_q == 5'(DIV_CYCLES));
  assign o_quot = quot_q;

  always_comb begin
    rem_in  = i_start ? '0 : rem_q;
    quot_in = i_start ? i_dividend : quot_q;
    div_in  = i_start ? i_divisor : div_q;
    trial   = {rem_in, quot_in[SUM_H_W-1]};
    fits    = trial >= {1'b0, div_in};

    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    step_d = step_q;
    busy_d = busy_q;

    if (i_start || (busy_q && !o_done)) begin
      div_d  = div_in;
      quot_d = {quot_in[SUM_H_W-2:0], fits};
      rem_d  = fits ? CNT_W'(trial - {1'b0, div_in}) : trial[CNT_W-1:0];
      step_d = i_start ? 5'd1 : step_q + 5'd1;
      busy_d = 1'b1;
    end else if (o_done) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/point_tracker.sv
// rtl/point_tracker.sv - per-frame marker centroid producer for the trajectory overlay
// Optional feature: POINT_TRACKER_SMOOTH_EN averages each new point with the previous output.
module point_tracker
  import point_tracker_pkg::*;
#(
  parameter int unsigned      FRAME_W   = FRAME_W_DEF,
  parameter int unsigned      FRAME_H   = FRAME_H_DEF,
  parameter logic [9:0]       G_TH      = 10'd600,
  parameter logic [9:0]       RB_TH     = 10'd300,
  parameter logic [CNT_W-1:0] MIN_COUNT = 19'd64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [29:0] i_color,
  input  logic [9:0]  i_h,
  input  logic [9:0]  i_v,
  input  logic        i_valid,
  output logic [9:0]  o_pointH,
  output logic [9:0]  o_pointV,
  output logic        o_pointVAL,
  output logic        o_busy
);

  localparam logic [9:0] LAST_H = 10'(FRAME_W - 1);
  localparam logic [9:0] LAST_V = 10'(FRAME_H - 1);

  tracker_state_t state_q, state_d;

  logic               marker, frame_end;
  logic [SUM_H_W-1:0] sum_h_q, sum_h_d, sum_h_now;
  logic [SUM_V_W-1:0] sum_v_q, sum_v_d, sum_v_now;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_now;
  logic [SUM_V_W-1:0] snap_v_q;
  logic [CNT_W-1:0]   snap_c_q;
  logic               snap_load;

  logic               div_start, div_done;
  logic [SUM_H_W-1:0] div_dividend, div_quot;
  logic [CNT_W-1:0]   div_divisor;
  logic               unused_quot_hi;

  logic               qh_load, emit_load;
  logic [9:0]         quot_h_q;
  logic [9:0]         point_h_q, point_v_q;
  logic               point_val_q;
  logic [9:0]         new_h, new_v;

  assign marker    = is_marker(i_valid, i_color, G_TH, RB_TH);
  assign frame_end = i_valid && (i_h == LAST_H) && (i_v == LAST_V);
  assign snap_load = frame_end && (state_q == IDLE);

  // sum_*_now include the current pixel so the frame-end pixel lands in the snapshot.
  always_comb begin
    sum_h_now = sum_h_q;
    sum_v_now = sum_v_q;
    cnt_now   = cnt_q;
    if (marker) begin
      sum_h_now = sum_h_q + SUM_H_W'(i_h);
      sum_v_now = sum_v_q + SUM_V_W'(i_v);
      cnt_now   = cnt_q + CNT_W'(1);
    end
    sum_h_d = frame_end ? '0 : sum_h_now;
    sum_v_d = frame_end ? '0 : sum_v_now;
    cnt_d   = frame_end ? '0 : cnt_now;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_h_q  <= '0;
      sum_v_q  <= '0;
      cnt_q    <= '0;
      snap_v_q <= '0;
      snap_c_q <= '0;
    end else begin
      sum_h_q <= sum_h_d;
      sum_v_q <= sum_v_d;
      cnt_q   <= cnt_d;
      if (snap_load) begin
        snap_v_q <= sum_v_now;
        snap_c_q <= cnt_now;
      end
    end
  end

  // The horizontal division starts on the frame-end edge itself; the divider's
  // operand registers hold the horizontal snapshot from then on.
  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = sum_h_now;
    div_divisor  = cnt_now;
    qh_load      = 1'b0;
    emit_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_end && (cnt_now >= MIN_COUNT)) begin
          state_d   = DIV_H;
          div_start = 1'b1;
        end
      end
      DIV_H: begin
        if (div_done) begin
          state_d      = DIV_V;
          div_start    = 1'b1;
          div_dividend = {1'b0, snap_v_q};
          div_divisor  = snap_c_q;
          qh_load      = 1'b1;
        end
      end
      DIV_V: begin
        if (div_done) begin
          state_d   = EMIT;
          emit_load = 1'b1;
        end
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  serial_divider u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (div_start),
    .i_dividend (div_dividend),
    .i_divisor  (div_divisor),
    .o_quot     (div_quot),
    .o_done     (div_done)
  );

  // Quotient never exceeds FRAME_W-1, so the upper bits are always zero.
  assign unused_quot_hi = &div_quot[SUM_H_W-1:10];

`ifdef POINT_TRACKER_SMOOTH_EN
  logic        have_prev_q;
  logic [10:0] avg_h_sum, avg_v_sum;
  logic        unused_avg_lsb;

  assign avg_h_sum      = {1'b0, point_h_q} + {1'b0, quot_h_q} + 11'd1;
  assign avg_v_sum      = {1'b0, point_v_q} + {1'b0, div_quot[9:0]} + 11'd1;
  assign unused_avg_lsb = avg_h_sum[0] ^ avg_v_sum[0];
  assign new_h          = have_prev_q ? avg_h_sum[10:1] : quot_h_q;
  assign new_v          = have_prev_q ? avg_v_sum[10:1] : div_quot[9:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      have_prev_q <= 1'b0;
    end else if (emit_load) begin
      have_prev_q <= 1'b1;
    end
  end
`else
  assign new_h = quot_h_q;
  assign new_v = div_quot[9:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      quot_h_q    <= '0;
      point_h_q   <= '0;
      point_v_q   <= '0;
      point_val_q <= 1'b0;
    end else begin
      point_val_q <= emit_load;
      if (qh_load) begin
        quot_h_q <= div_quot[9:0];
      end
      if (emit_load) begin
        point_h_q <= new_h;
        point_v_q <= new_v;
      end
    end
  end

  assign o_pointH   = point_h_q;
  assign o_pointV   = point_v_q;
  assign o_pointVAL = point_val_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_point_tracker.sv
// tb/tb_point_tracker.sv - directed self-checking bench for point_tracker
module tb_point_tracker;

  localparam logic [29:0] MK      = {10'd0, 10'd1023, 10'd0};
  localparam logic [29:0] MK_EDGE = {10'd299, 10'd600, 10'd299};
  localparam logic [29:0] NM_G    = {10'd0, 10'd599, 10'd0};
  localparam logic [29:0] NM_R    = {10'd300, 10'd1023, 10'd0};
  localparam logic [29:0] NM_B    = {10'd0, 10'd1023, 10'd300};
  localparam logic [29:0] BG      = {10'd500, 10'd500, 10'd500};

  logic        clk;
  logic        rst;
  logic [29:0] color;
  logic [9:0]  h, v;
  logic        valid;

  logic [9:0]  pt_h_a, pt_v_a, pt_h_b, pt_v_b;
  logic        val_a, busy_a, val_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse_a = 0;
  int n_pulse_b = 0;
  bit busy_seen_a = 0;

  int exp_h = 0;
  int exp_v = 0;
  bit have_prev = 0;

  point_tracker #(.MIN_COUNT(19'd16)) dut (
    .i_clk(clk), .i_rst(rst), .i_color(color), .i_h(h), .i_v(v), .i_valid(valid),
    .o_pointH(pt_h_a), .o_pointV(pt_v_a), .o_pointVAL(val_a), .o_busy(busy_a)
  );

  point_tracker #(.MIN_COUNT(19'd1)) dut_one (
    .i_clk(clk), .i_rst(rst), .i_color(color), .i_h(h), .i_v(v), .i_valid(valid),
    .o_pointH(pt_h_b), .o_pointV(pt_v_b), .o_pointVAL(val_b), .o_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (val_a) n_pulse_a++;
    if (val_b) n_pulse_b++;
    if (busy_a) busy_seen_a = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input logic [9:0] ph, input logic [9:0] pv, input logic [29:0] c, input logic pval);
    h = ph; v = pv; color = c; valid = pval;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic square(input int h0, input int v0, input logic [29:0] c);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        pix(10'(h0 + i), 10'(v0 + j), c, 1'b1);
  endtask

  task automatic frame_end(input logic [29:0] c);
    pix(10'd639, 10'd479, c, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    exp_h = 0; exp_v = 0; have_prev = 1'b0;
  endtask

  // Call right after frame_end: lat is the cycle index relative to the frame-end pixel.
  task automatic wait_pulse(input bit sel_b, output int lat);
    lat = 1;
    while (!(sel_b ? val_b : val_a) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_point(input string tag, input int nh, input int nv);
`ifdef POINT_TRACKER_SMOOTH_EN
    if (have_prev) begin
      exp_h = (exp_h + nh + 1) >> 1;
      exp_v = (exp_v + nv + 1) >> 1;
    end else begin
      exp_h = nh; exp_v = nv;
    end
`else
    exp_h = nh; exp_v = nv;
`endif
    have_prev = 1'b1;
    check({tag, "_h"}, 32'(pt_h_a), 32'(exp_h));
    check({tag, "_v"}, 32'(pt_v_a), 32'(exp_v));
  endtask

  initial begin
    int lat;
    int n0;
    rst = 1'b0; color = '0; h = '0; v = '0; valid = 1'b0;
    @(posedge clk); #1;
    do_reset();

    check("rst_h", 32'(pt_h_a), 0);
    check("rst_v", 32'(pt_v_a), 0);
    check("rst_val", 32'(val_a), 0);
    check("rst_busy", 32'(busy_a), 0);

    // Single square with threshold-edge colour plus rejected near-miss pixels.
    pix(10'd100, 10'd200, NM_G, 1'b1);
    pix(10'd100, 10'd200, NM_R, 1'b1);
    pix(10'd100, 10'd200, NM_B, 1'b1);
    pix(10'd100, 10'd200, MK, 1'b0);
    square(100, 200, MK_EDGE);
    n0 = n_pulse_a;
    frame_end(BG);
    check("sq_busy_first", 32'(busy_a), 1);
    wait_pulse(1'b0, lat);
    check("sq_latency", 32'(lat), 59);
    check("sq_busy_last", 32'(busy_a), 1);
    expect_point("sq", 101, 201);
    idle(1);
    check("sq_val_one_cycle", 32'(val_a), 0);
    check("sq_busy_after", 32'(busy_a), 0);
    check("sq_pulses", 32'(n_pulse_a - n0), 1);

    // Below threshold: no pulse, no busy, outputs hold.
    busy_seen_a = 1'b0;
    n0 = n_pulse_a;
    for (int i = 0; i < 10; i++) pix(10'(20 + i), 10'd30, MK, 1'b1);
    frame_end(BG);
    idle(70);
    check("low_busy", 32'(busy_seen_a), 0);
    check("low_pulses", 32'(n_pulse_a - n0), 0);
    check("low_hold_h", 32'(pt_h_a), 32'(exp_h));
    check("low_hold_v", 32'(pt_v_a), 32'(exp_v));

    // Frame-end pixel is itself the only marker.
    do_reset();
    busy_seen_a = 1'b0;
    n0 = n_pulse_a;
    frame_end(MK);
    wait_pulse(1'b1, lat);
    check("fe_latency", 32'(lat), 59);
    check("fe_h", 32'(pt_h_b), 639);
    check("fe_v", 32'(pt_v_b), 479);
    check("fe_min16_pulses", 32'(n_pulse_a - n0), 0);
    check("fe_min16_busy", 32'(busy_seen_a), 0);

    // Back-to-back: second frame ends 20 cycles after the first and is dropped.
    do_reset();
    n0 = n_pulse_a;
    square(300, 50, MK);
    frame_end(BG);
    square(10, 10, MK);
    idle(3);
    frame_end(BG);
    idle(70);
    check("b2b_pulses", 32'(n_pulse_a - n0), 1);
    expect_point("b2b_first", 301, 51);
    square(500, 400, MK);
    frame_end(BG);
    wait_pulse(1'b0, lat);
    check("b2b_third_latency", 32'(lat), 59);
    expect_point("b2b_third", 501, 401);

    // Reset mid-division.
    do_reset();
    square(200, 300, MK);
    frame_end(BG);
    idle(39);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_h = 0; exp_v = 0; have_prev = 1'b0;
    n0 = n_pulse_a;
    idle(40);
    check("abort_pulses", 32'(n_pulse_a - n0), 0);
    check("abort_h", 32'(pt_h_a), 0);
    check("abort_v", 32'(pt_v_a), 0);
    check("abort_val", 32'(val_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    square(50, 60, MK);
    frame_end(BG);
    wait_pulse(1'b0, lat);
    check("abort_next_latency", 32'(lat), 59);
    expect_point("abort_next", 51, 61);

    // Two consecutive points (smoothed when the feature is built in).
    do_reset();
    square(99, 99, MK);
    frame_end(BG);
    wait_pulse(1'b0, lat);
    expect_point("pair_first", 100, 100);
    square(200, 49, MK);
    frame_end(BG);
    wait_pulse(1'b0, lat);
    check("pair_second_latency", 32'(lat), 59);
    expect_point("pair_second", 201, 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
